// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the instruction fetch queue
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, exposing occupancy and head entry
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head_data
);

  // Pointer width never drops to zero so DEPTH=1 still has a legal index.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [2**PW];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Credit logic upstream must never let a push land on a full queue.
  always_ff @(posedge CLK) begin
    if (rst_n && push && !flush) assert (count != CW'(DEPTH));
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch stage: issues imem reads, tags returns with byte PC, queues for decode
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int IMEM_AW = 10
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  PC_Word,
  input  logic               Flush,
  output logic               En_PC,
  output logic               IMem_Rd_En,
  output logic [IMEM_AW-1:0] IMem_Addr,
  input  logic [DATA_W-1:0]  IMem_Data,
  output logic               Instr_Valid,
  output logic [DATA_W-1:0]  Instr_Out,
  output logic [ADDR_W-1:0]  Instr_PC,
  input  logic               Dec_Ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DATA_W + ADDR_W;

  logic              req_v;
  logic [ADDR_W-1:0] req_pc;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [CW:0]       occupancy;

  assign Instr_Valid = (count != '0);
  assign pop         = Instr_Valid && Dec_Ready && !Flush;
  assign push        = req_v && !Flush;

  // Entries held plus the read in flight, after this cycle's pop; issue only if it still fits.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, req_v} - {{CW{1'b0}}, pop};
  assign En_PC      = Flush | (occupancy < (CW + 1)'(DEPTH));
  assign IMem_Rd_En = En_PC & rst_n;
  assign IMem_Addr  = PC_Word[IMEM_AW-1:0];

  // A read issued in the flush cycle still fetches the old path, so its tag is dropped.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      req_v  <= 1'b0;
      req_pc <= '0;
    end else begin
      req_v <= IMem_Rd_En && !Flush;
      if (IMem_Rd_En) req_pc <= PC_Word;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .flush    (Flush),
    .push     (push),
    .push_data({IMem_Data, req_pc << 2}),
    .pop      (pop),
    .count    (count),
    .head_data(head)
  );

  assign Instr_Out = Instr_Valid ? head[EW-1:ADDR_W] : DATA_W'(NOP_INSTR);
  assign Instr_PC  = Instr_Valid ? head[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue at DEPTH=2 and DEPTH=1
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n, Flush, Dec_Ready;
  logic [31:0] target;
  logic [31:0] pcw0, pcw1, data0, data1, out0, out1, ipc0, ipc1;
  logic        en0, en1, rd0, rd1, valid0, valid1;
  logic [9:0]  addr0, addr1;

  instr_fetch_queue #(.DEPTH(2)) u0 (
    .CLK(CLK), .rst_n(rst_n), .PC_Word(pcw0), .Flush(Flush), .En_PC(en0),
    .IMem_Rd_En(rd0), .IMem_Addr(addr0), .IMem_Data(data0), .Instr_Valid(valid0),
    .Instr_Out(out0), .Instr_PC(ipc0), .Dec_Ready(Dec_Ready)
  );

  instr_fetch_queue #(.DEPTH(1)) u1 (
    .CLK(CLK), .rst_n(rst_n), .PC_Word(pcw1), .Flush(Flush), .En_PC(en1),
    .IMem_Rd_En(rd1), .IMem_Addr(addr1), .IMem_Data(data1), .Instr_Valid(valid1),
    .Instr_Out(out1), .Instr_PC(ipc1), .Dec_Ready(Dec_Ready)
  );

  // PC registers and instruction memories (mem[i] = 0x1000 + i)
  always @(posedge CLK or negedge rst_n)
    if (!rst_n) pcw0 <= 0; else if (Flush) pcw0 <= target; else if (en0) pcw0 <= pcw0 + 1;
  always @(posedge CLK or negedge rst_n)
    if (!rst_n) pcw1 <= 0; else if (Flush) pcw1 <= target; else if (en1) pcw1 <= pcw1 + 1;
  always @(posedge CLK) if (rd0) data0 <= 32'h1000 + {22'b0, addr0};
  always @(posedge CLK) if (rd1) data1 <= 32'h1000 + {22'b0, addr1};

  int total = 0;
  int bad   = 0;
  int pops1 = 0;
  fetch_entry_t sb0[$];
  fetch_entry_t sb1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input int k, input fetch_entry_t h);
    fetch_entry_t e;
    int sz;
    sz = (k == 0) ? sb0.size() : sb1.size();
    total++;
    assert (sz != 0) else begin
      bad++;
      $error("FAIL sb%0d_extra observed_pc=%h expected=none", k, h.pc);
    end
    if (sz != 0) begin
      if (k == 0) e = sb0.pop_front(); else e = sb1.pop_front();
      chk($sformatf("sb%0d_instr", k), h.instr, e.instr);
      chk($sformatf("sb%0d_pc", k), h.pc, e.pc);
    end
  endtask

  // One clock: sample just before the edge, then score pops and record issued reads.
  task automatic cycle();
    logic rs, fl, iss0, iss1, p0, p1;
    fetch_entry_t e0, e1, h0, h1;
    #1;
    rs   = rst_n;
    fl   = Flush;
    iss0 = rd0;
    iss1 = rd1;
    p0   = valid0 && Dec_Ready && !Flush;
    p1   = valid1 && Dec_Ready && !Flush;
    e0   = '{instr: 32'h1000 + {22'b0, pcw0[9:0]}, pc: pcw0 << 2};
    e1   = '{instr: 32'h1000 + {22'b0, pcw1[9:0]}, pc: pcw1 << 2};
    h0   = '{instr: out0, pc: ipc0};
    h1   = '{instr: out1, pc: ipc1};
    if (!valid0) begin
      chk("idle_out0", out0, NOP_INSTR);
      chk("idle_pc0", ipc0, 0);
    end
    @(posedge CLK);
    if (!rs || fl) begin
      sb0.delete();
      sb1.delete();
    end else begin
      if (p0) pop_chk(0, h0);
      if (p1) begin
        pops1++;
        pop_chk(1, h1);
      end
      if (iss0) sb0.push_back(e0);
      if (iss1) sb1.push_back(e1);
    end
    @(negedge CLK);
  endtask

  initial begin
    int n;
    rst_n = 0; Flush = 0; Dec_Ready = 0; target = 0;
    @(negedge CLK); @(negedge CLK);
    chk("rst_valid", valid0, 0);
    chk("rst_rd_en", rd0, 0);
    rst_n = 1;

    // Reset mid-stream with two entries queued
    repeat (3) cycle();
    chk("pre_rst_valid", valid0, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_valid", valid0, 0);
    chk("rst_mid_out", out0, NOP_INSTR);
    chk("rst_mid_pc", ipc0, 0);
    chk("rst_mid_rd_en", rd0, 0);
    cycle();
    rst_n = 1;
    #1;
    chk("post_rst_en", en0, 1);

    // Streaming with decode always ready
    Dec_Ready = 1;
    chk("s_valid_c0", valid0, 0);
    cycle();
    chk("s_valid_c1", valid0, 0);
    cycle();
    chk("s_valid_c2", valid0, 1);
    chk("s_first_out", out0, 32'h1000);
    chk("s_first_pc", ipc0, 0);
    n = pops1;
    for (int i = 0; i < 10; i++) begin
      chk("s_en_pc", en0, 1);
      cycle();
    end
    chk("d1_rate", pops1 - n, 5);

    // Backpressure from reset
    rst_n = 0; Dec_Ready = 0;
    cycle();
    rst_n = 1;
    cycle(); cycle();
    chk("bp_en_off", en0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_en_hold", en0, 0);
    end
    chk("bp_valid", valid0, 1);
    chk("bp_head", out0, 32'h1000);
    Dec_Ready = 1;
    repeat (8) cycle();

    // Flush with a full queue
    Dec_Ready = 0;
    repeat (3) cycle();
    chk("ff_full_valid", valid0, 1);
    chk("ff_full_en", en0, 0);
    Flush = 1; target = 16;
    #1;
    chk("ff_en", en0, 1);
    cycle();
    Flush = 0;
    chk("ff_valid_c1", valid0, 0);
    cycle();
    chk("ff_valid_c2", valid0, 0);
    cycle();
    chk("ff_valid_c3", valid0, 1);
    chk("ff_pc", ipc0, 32'h40);
    chk("ff_out", out0, 32'h1010);

    // Flush coincident with a pop and a push
    Dec_Ready = 1;
    repeat (4) cycle();
    chk("fc_valid", valid0, 1);
    Flush = 1; target = 32;
    cycle();
    Flush = 0;
    chk("fc_valid_c1", valid0, 0);
    cycle();
    chk("fc_valid_c2", valid0, 0);
    cycle();
    chk("fc_valid_c3", valid0, 1);
    chk("fc_pc", ipc0, 32'h80);
    chk("fc_out", out0, 32'h1020);
    repeat (6) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
